spi_target: RTL and testbench
=============================

# spi_target

SPI mode-0 target (slave) running entirely in the `clk` domain. It gives an external SPI initiator byte-wide read and write access to a 32-entry register window of game state, and is the responding end of the same SPI protocol the SoC's `spi0` master drives. Typical registers in the window are player and bomb position/velocity, HP and keycode overrides. `SCLK`, `SS_N` and `MOSI` are oversampled; there are no extra clock domains.

## Interface

Parameters:
- `ADDR_W`, default 5: register address width; 32 registers.
- `SYNC_STAGES`, default 2: synchronizer depth on `sclk`, `ss_n` and `mosi`.

Ports:
- `clk` in 1: system clock, `CLOCK_50`.
- `reset_n` in 1: asynchronous, active-low reset.
- `sclk` in 1: SPI clock from the initiator. Maximum frequency is `clk`/8.
- `ss_n` in 1: SPI select, active low.
- `mosi` in 1: initiator data, MSB first.
- `miso` out 1: target data, MSB first.
- `miso_oe` out 1: MISO drive enable; high while selected.
- `rd_addr` out `ADDR_W`: register read address.
- `rd_data` in 8: register read data, sampled the cycle after `rd_addr` changes.
- `wr_en` out 1: one-cycle write strobe.
- `wr_addr` out `ADDR_W`: write address, valid with `wr_en`.
- `wr_data` out 8: write data, valid with `wr_en`.
- `busy` out 1: high when state is not IDLE.
- `xfer_done` out 1: one-cycle pulse at deselect after at least one complete data byte.
- `abort_err` out 1: sticky flag set by a deselect mid-byte; cleared only by reset.

## Operation

- Input conditioning:
  - Each input passes through `SYNC_STAGES` flops, then one registered edge-detect stage.
  - Events `sclk_rise`, `sclk_fall` and `sel_fall` are each asserted for one cycle.
  - `mosi` is taken from the same sync stage as `sclk`.
- Frame format:
  - The first byte is the command: bit7 = 1 write, 0 read; bits 6:5 ignored; bits 4:0 start address.
  - Every following byte is data, with the address auto-incrementing after each data byte.
  - The address wraps from 31 to 0.
- States: IDLE, CMD, DATA.
  - IDLE -> CMD on synced `ss_n` low. Clear `bit_cnt` (3 bits) and the shift registers.
  - CMD: shift `mosi` in on each `sclk_rise`. After the 8th rise, latch `dir` and `addr`, then go to DATA. For a read, drive `rd_addr` = addr that cycle.
  - DATA, write:
    - Shift `mosi` on `sclk_rise`.
    - After the 8th rise, `wr_en`=1 for exactly one cycle, with `wr_addr`=addr and `wr_data`=the received byte.
    - Then addr = addr+1 mod 32.
  - DATA, read:
    - Load the TX shift register with `rd_data` one cycle after `rd_addr` is driven.
    - Present TX bit7 on `miso` at the `sclk_fall` following the byte boundary, then shift on each later `sclk_fall`.
    - After each 8th rise, increment addr, drive the new `rd_addr`, and prefetch the next byte.
  - Any state -> IDLE on synced `ss_n` high. This takes priority over a same-cycle `sclk` edge.
    - If `bit_cnt` != 0, no `wr_en` is issued for the partial byte and `abort_err` is set.
    - If at least one full data byte completed, `xfer_done` pulses.
- `miso` is 0 throughout CMD and during write frames.
- `miso_oe` equals the synced select (`~ss_n`).
- `sclk` edges while deselected are ignored.

## Timing

- Reset values (async on `reset_n` low): state=IDLE, `miso`=0, `miso_oe`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `rd_addr`=0, `busy`=0, `xfer_done`=0, `abort_err`=0.
- Pin-to-event latency is `SYNC_STAGES`+1 = 3 clk.
- `wr_en` asserts 1 clk after the 8th `sclk_rise` event, i.e. 4 clk after the pin edge.
- Read prefetch: `rd_addr` is valid 1 clk after the 8th rise event, and `rd_data` is captured the next clk. That is 2 clk total, which fits within the minimum 4-clk SCLK half-period.
- `miso` changes 4 clk after the `sclk` falling pin edge. It is stable well before the next rising edge at `clk`/8.
- `reset_n` asserted mid-frame: all state clears immediately. The remainder of that frame is ignored until `ss_n` goes high and then low again.
- Back-to-back frames need `ss_n` high for at least 4 clk.

## Test plan

- Write frame: command 0x83, data 0x5A, 0xA5 at `clk`/8 -> `wr_en` pulses twice, (addr 3, 0x5A) then (addr 4, 0xA5); `xfer_done` pulses once; `abort_err`=0.
- Read frame: command 0x1F with a model returning `rd_data`=addr ^ 0xC0, clocking 2 data bytes -> `miso` shifts 0xDF then 0xC0 (addr wrapped 31 -> 0); `miso`=0 during the command byte.
- Abort: command 0x80, then 5 data bits, then `ss_n` high -> no `wr_en`, `abort_err`=1, `xfer_done`=0, `busy`=0 within 4 clk.
- Simultaneous events: `ss_n` rises in the same clk as the 8th `sclk` rise of a data byte -> deselect wins; no `wr_en`; `abort_err`=1.
- Reset mid-transfer: `reset_n` low during byte 2 of a write -> all outputs at reset values the same cycle. A fresh frame 0x81, 0x11 then writes (1, 0x11).
- Idle noise: `sclk` toggling with `ss_n` high for 100 edges -> `busy`=0, `miso_oe`=0, no `wr_en`.

Source files
------------

// File: rtl/spi_target.sv
// spi_target: SPI mode-0 target giving an external initiator byte-wide
// read/write access to a 2**ADDR_W register window. All SPI pins are
// oversampled in the clk domain; there is no second clock domain.
//
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   sclk, ss_n, mosi    SPI pins from the initiator (asynchronous)
//   miso, miso_oe       SPI data back to the initiator and its drive enable
//   rd_addr, rd_data    register read port (rd_data sampled a cycle after rd_addr)
//   wr_en, wr_addr,
//   wr_data             one-cycle register write strobe with address/data
//   busy                frame in progress (state not IDLE)
//   xfer_done           pulse at deselect after at least one full data byte
//   abort_err           sticky: deselect arrived mid-byte
module spi_target #(
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sclk,
  input  logic              ss_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              xfer_done,
  output logic              abort_err
);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  // Input synchronizers and registered edge detection
  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic sclk_s, ss_s, mosi_s;
  logic sclk_prev, ss_prev, sclk_rise, sclk_fall, sel_fall, mosi_q;
  logic armed, sel_q;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // The ss_n chain resets low and 'armed' only sets once a genuine high is
  // seen, so a frame cut by reset is ignored until the next select edge and
  // miso_oe never glitches high while the chain refills.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync <= '0;
      ss_sync   <= '0;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      ss_prev   <= 1'b0;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
      sel_fall  <= 1'b0;
      mosi_q    <= 1'b0;
      armed     <= 1'b0;
      sel_q     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_prev <= sclk_s;
      ss_prev   <= ss_s;
      sclk_rise <= sclk_s & ~sclk_prev;
      sclk_fall <= ~sclk_s & sclk_prev;
      sel_fall  <= ss_prev & ~ss_s;
      mosi_q    <= mosi_s;
      armed     <= armed | ss_s;
      sel_q     <= armed & ~ss_s;
    end
  end

  // Frame FSM and datapath
  state_t            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        rx_q, rx_d, rx_next;
  logic [7:0]        tx_q, tx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              dir_q, dir_d;
  logic              got_q, got_d;
  logic              load_q, load_d;
  logic              miso_q, miso_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              done_q, done_d;
  logic              abort_q, abort_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      addr_q    <= '0;
      dir_q     <= 1'b0;
      got_q     <= 1'b0;
      load_q    <= 1'b0;
      miso_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_addr_q <= '0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      addr_q    <= addr_d;
      dir_q     <= dir_d;
      got_q     <= got_d;
      load_q    <= load_d;
      miso_q    <= miso_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_addr_q <= rd_addr_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    addr_d    = addr_q;
    dir_d     = dir_q;
    got_d     = got_q;
    load_d    = 1'b0;
    miso_d    = miso_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_addr_d = rd_addr_q;
    done_d    = 1'b0;
    abort_d   = abort_q;
    rx_next   = {rx_q[6:0], mosi_q};

    // Prefetch: rd_data is captured the cycle after rd_addr was driven
    if (load_q) tx_d = rd_data;

    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (sel_fall) begin
          state_d   = CMD;
          bit_cnt_d = '0;
          rx_d      = '0;
          tx_d      = '0;
          got_d     = 1'b0;
        end
      end
      default: begin
        // Deselect is checked first so it wins over a same-cycle sclk edge
        if (ss_prev) begin
          state_d = IDLE;
          miso_d  = 1'b0;
          if (bit_cnt_q != 3'd0) abort_d = 1'b1;
          if (got_q) done_d = 1'b1;
        end else if (sclk_rise) begin
          rx_d      = rx_next;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (state_q == CMD) begin
              state_d = DATA;
              dir_d   = rx_next[7];
              addr_d  = rx_next[ADDR_W-1:0];
              if (!rx_next[7]) begin
                rd_addr_d = rx_next[ADDR_W-1:0];
                load_d    = 1'b1;
              end
            end else begin
              got_d  = 1'b1;
              addr_d = addr_q + 1'b1;
              if (dir_q) begin
                wr_en_d   = 1'b1;
                wr_addr_d = addr_q;
                wr_data_d = rx_next;
              end else begin
                rd_addr_d = addr_q + 1'b1;
                load_d    = 1'b1;
              end
            end
          end
        end else if (sclk_fall && state_q == DATA && !dir_q) begin
          miso_d = tx_q[7];
          tx_d   = {tx_q[6:0], 1'b0};
        end
      end
    endcase
  end

  assign miso      = miso_q;
  assign miso_oe   = sel_q;
  assign rd_addr   = rd_addr_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = (state_q != IDLE);
  assign xfer_done = done_q;
  assign abort_err = abort_q;

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: write/read frames, abort, deselect racing
// the 8th sclk rise, reset mid-frame, and sclk noise while deselected.
module tb_spi_target;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sclk = 1'b0;
  logic       ss_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso, miso_oe, wr_en, busy, xfer_done, abort_err;
  logic [4:0] rd_addr, wr_addr;
  logic [7:0] rd_data, wr_data;

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  logic [4:0] wlog_a [16];
  logic [7:0] wlog_d [16];

  spi_target #(.ADDR_W(5), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .xfer_done(xfer_done), .abort_err(abort_err)
  );

  always #5 clk = ~clk;

  // Register file model for reads
  assign rd_data = {3'b000, rd_addr} ^ 8'hC0;

  always @(negedge clk) begin
    if (wr_en) begin
      if (wr_cnt < 16) begin
        wlog_a[wr_cnt] = wr_addr;
        wlog_d[wr_cnt] = wr_data;
      end
      wr_cnt++;
    end
    if (xfer_done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends the n most significant bits of tb at clk/8, returns sampled miso
  task automatic xbits(input logic [7:0] tb, input int n, output logic [7:0] rb);
    rb = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      mosi = tb[i];
      wclk(4);
      rb[i] = miso;
      sclk = 1'b1;
      wclk(4);
      sclk = 1'b0;
    end
  endtask

  task automatic deselect();
    wclk(4);
    ss_n = 1'b1;
    wclk(8);
  endtask

  logic [7:0] r0, r1, r2;
  int bad;

  initial begin
    // Reset state
    wclk(2);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_oe", 32'(miso_oe), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_abort", 32'(abort_err), 32'd0);
    reset_n = 1'b1;
    wclk(6);

    // Write frame 0x83, 0x5A, 0xA5
    ss_n = 1'b0;
    wclk(4);
    xbits(8'h83, 8, r0);
    check("wr_busy", 32'(busy), 32'd1);
    check("wr_oe", 32'(miso_oe), 32'd1);
    xbits(8'h5A, 8, r1);
    xbits(8'hA5, 8, r2);
    deselect();
    check("wr_miso_bytes", {8'h0, r0, r1, r2}, 32'h0);
    check("wr_count", 32'(wr_cnt), 32'd2);
    check("wr0_addr", 32'(wlog_a[0]), 32'd3);
    check("wr0_data", 32'(wlog_d[0]), 32'h5A);
    check("wr1_addr", 32'(wlog_a[1]), 32'd4);
    check("wr1_data", 32'(wlog_d[1]), 32'hA5);
    check("wr_done", 32'(done_cnt), 32'd1);
    check("wr_abort", 32'(abort_err), 32'd0);
    check("wr_idle_oe", 32'(miso_oe), 32'd0);

    // Read frame 0x1F, two data bytes, address wraps 31 -> 0
    ss_n = 1'b0;
    wclk(4);
    xbits(8'h1F, 8, r0);
    xbits(8'h00, 8, r1);
    xbits(8'h00, 8, r2);
    deselect();
    check("rd_cmd_miso", 32'(r0), 32'h00);
    check("rd_byte0", 32'(r1), 32'hDF);
    check("rd_byte1", 32'(r2), 32'hC0);
    check("rd_addr_wrap", 32'(rd_addr), 32'd1);
    check("rd_no_write", 32'(wr_cnt), 32'd2);
    check("rd_done", 32'(done_cnt), 32'd2);

    // Abort: command 0x80 then 5 data bits
    ss_n = 1'b0;
    wclk(4);
    xbits(8'h80, 8, r0);
    xbits(8'hFF, 5, r1);
    ss_n = 1'b1;
    wclk(4);
    check("ab_busy", 32'(busy), 32'd0);
    wclk(4);
    check("ab_abort", 32'(abort_err), 32'd1);
    check("ab_no_write", 32'(wr_cnt), 32'd2);
    check("ab_no_done", 32'(done_cnt), 32'd2);

    // Reset during byte 2 of a write frame
    ss_n = 1'b0;
    wclk(4);
    xbits(8'h82, 8, r0);
    xbits(8'h33, 8, r1);
    xbits(8'hF0, 3, r2);
    check("pre_rst_wr", 32'(wr_cnt), 32'd3);
    check("pre_rst_busy", 32'(busy), 32'd1);
    wclk(2);
    reset_n = 1'b0;
    #1;
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_oe", 32'(miso_oe), 32'd0);
    check("mr_wr_addr", 32'(wr_addr), 32'd0);
    check("mr_wr_data", 32'(wr_data), 32'd0);
    check("mr_rd_addr", 32'(rd_addr), 32'd0);
    check("mr_abort", 32'(abort_err), 32'd0);
    check("mr_miso", 32'(miso), 32'd0);
    check("mr_done", 32'(xfer_done), 32'd0);
    wclk(2);
    reset_n = 1'b1;
    xbits(8'hFF, 5, r2);
    check("mr_ignored_busy", 32'(busy), 32'd0);
    deselect();
    check("mr_ignored_wr", 32'(wr_cnt), 32'd3);
    ss_n = 1'b0;
    wclk(4);
    xbits(8'h81, 8, r0);
    xbits(8'h11, 8, r1);
    deselect();
    check("fresh_count", 32'(wr_cnt), 32'd4);
    check("fresh_addr", 32'(wlog_a[3]), 32'd1);
    check("fresh_data", 32'(wlog_d[3]), 32'h11);
    check("fresh_done", 32'(done_cnt), 32'd3);
    check("fresh_abort", 32'(abort_err), 32'd0);

    // ss_n rises together with the 8th sclk rise of a data byte
    ss_n = 1'b0;
    wclk(4);
    xbits(8'h80, 8, r0);
    xbits(8'hFF, 7, r1);
    mosi = 1'b1;
    wclk(4);
    sclk = 1'b1;
    ss_n = 1'b1;
    wclk(8);
    sclk = 1'b0;
    wclk(8);
    check("race_no_write", 32'(wr_cnt), 32'd4);
    check("race_abort", 32'(abort_err), 32'd1);
    check("race_done", 32'(done_cnt), 32'd3);
    check("race_busy", 32'(busy), 32'd0);

    // sclk noise while deselected
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      sclk = ~sclk;
      mosi = i[0];
      wclk(4);
      if (busy || miso_oe || wr_en) bad++;
    end
    check("noise_quiet", 32'(bad), 32'd0);
    check("noise_no_write", 32'(wr_cnt), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
